// File: rtl/aes_256_word_loader.sv
// Word-serial front end for the AES-256 core: packs key and block words, runs the
// core's En/done handshake with a watchdog, then streams the 128-bit result out.
module aes_256_word_loader #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_is_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic [255:0] core_key,
    output logic [127:0] core_data_in,
    output logic         core_en,
    input  logic [127:0] core_data_out,
    input  logic         core_done,
    output logic         key_valid,
    output logic         busy,
    output logic         error
);
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [9:0] WD_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    // Word 0 is the most significant word, so word k lives at index (N-1-k) == ~k.
    logic [7:0][31:0] key_reg;
    logic [3:0][31:0] blk_reg;
    logic [3:0][31:0] res_reg;
    logic [2:0]       key_cnt;
    logic [1:0]       data_cnt;
    logic [1:0]       out_cnt;
    logic [9:0]       wd_cnt;
    logic             key_valid_q;
    logic             error_q;
    logic             core_en_q;

    logic             key_fire;
    logic             data_fire;
    logic             out_fire;
    logic             wd_expired;

    assign key_fire   = in_valid & in_ready & in_is_key;
    assign data_fire  = in_valid & in_ready & ~in_is_key;
    assign out_fire   = out_valid & out_ready;
    assign wd_expired = (wd_cnt == WD_LAST);

    always_ff @(posedge Clk) begin
        if (Rst) state <= LOAD;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (data_fire && data_cnt == 2'd3) state_next = RUN;
            // A done arriving on the last watchdog cycle still completes the block.
            RUN:     if (core_done)       state_next = DRAIN;
                     else if (wd_expired) state_next = LOAD;
            DRAIN:   if (out_fire && out_cnt == 2'd3) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        case (state)
            LOAD: in_ready = in_is_key ? (data_cnt == 2'd0) : key_valid_q;
            RUN:  busy = 1'b1;
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = res_reg[~out_cnt];
                out_last  = (out_cnt == 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            key_reg     <= '0;
            blk_reg     <= '0;
            res_reg     <= '0;
            key_cnt     <= '0;
            data_cnt    <= '0;
            out_cnt     <= '0;
            wd_cnt      <= '0;
            key_valid_q <= 1'b0;
            error_q     <= 1'b0;
            core_en_q   <= 1'b0;
        end else begin
            if (key_fire) begin
                key_reg[~key_cnt] <= in_data;
                key_cnt           <= key_cnt + 3'd1;
                // Starting a new key invalidates the old one and acknowledges any timeout.
                if (key_cnt == 3'd0) begin
                    key_valid_q <= 1'b0;
                    error_q     <= 1'b0;
                end
                if (key_cnt == 3'd7) key_valid_q <= 1'b1;
            end
            if (data_fire) begin
                blk_reg[~data_cnt] <= in_data;
                data_cnt           <= data_cnt + 2'd1;
            end
            wd_cnt <= (state == RUN) ? wd_cnt + 10'd1 : 10'd0;
            if (state == RUN && core_done)                 res_reg <= core_data_out;
            if (state == RUN && !core_done && wd_expired)  error_q <= 1'b1;
            if (out_fire) out_cnt <= out_cnt + 2'd1;
            core_en_q <= (state_next == RUN);
        end
    end

    assign core_key     = key_reg;
    assign core_data_in = blk_reg;
    assign core_en      = core_en_q;
    assign key_valid    = key_valid_q;
    assign error        = error_q;

endmodule

// File: doc/aes_256_word_loader.md
Name: aes_256_word_loader

Overview:
- Word-serial front end directly upstream of the AES_256 core.
- Assembles a 256-bit cipher key (8 words) and a 128-bit data block (4 words) from a 32-bit valid/ready input stream.
- Drives the core's En/done handshake with a watchdog, captures the 128-bit result and returns it as 4 words on a 32-bit valid/ready output stream.
- The key persists across blocks, so one key load serves many blocks.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in RUN waiting for core_done before aborting; legal range 2..1023.

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid & in_ready.
- in_data  in  32  key or data word.
- in_is_key  in  1  1 = in_data is a key word; 0 = data word.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts the result word.
- out_data  out  32  result word.
- out_last  out  1  high with the 4th result word.
- core_key  out  256  to core cipher_key; the key register.
- core_data_in  out  128  to core data_in; the block register.
- core_en  out  1  to core En.
- core_data_out  in  128  from core data_out.
- core_done  in  1  from core done.
- key_valid  out  1  all 8 key words are loaded.
- busy  out  1  state is RUN or DRAIN.
- error  out  1  sticky watchdog-timeout flag.

Behaviour:
- Reset: state LOAD. key_reg, blk_reg, res_reg and all counters are 0. Outputs in_ready, out_valid, out_last, core_en, key_valid, busy and error are 0; out_data, core_key and core_data_in are 0.
- Reset mid-operation aborts everything, and all of the above values hold the cycle after the Rst edge.
- Word order is MSW first:
  - key word k (0..7) lands in key_reg[255-32k -: 32];
  - data word k (0..3) lands in blk_reg[127-32k -: 32];
  - result word k is res_reg[127-32k -: 32].
- States: LOAD, RUN, DRAIN.
- LOAD, key words:
  - in_ready = (in_is_key ? (data_cnt==0) : key_valid).
  - An accepted key word with key_cnt==0 clears key_valid and clears error.
  - key_cnt increments and wraps at 7→0. On the 8th word key_valid=1 from the next cycle.
  - Key words offered while data_cnt!=0 stall with in_ready=0.
- LOAD, data words:
  - Data words are stalled (in_ready=0) while key_valid=0.
  - On the 4th accepted data word: data_cnt→0, next state RUN.
- RUN:
  - core_en=1 (registered) from the cycle after the 4th data word is accepted, so the core sees core_en one cycle after acceptance.
  - in_ready=0 and busy=1.
  - wd_cnt starts at 0 on entry and increments each RUN cycle.
  - On the first RUN cycle with core_done=1: res_reg <= core_data_out, next state DRAIN, core_en=0 next cycle.
  - If wd_cnt==TIMEOUT_CYCLES-1 and core_done=0: error=1, core_en=0, state LOAD, and the block is discarded (key kept).
  - If core_done and the timeout fall in the same cycle, done wins.
- DRAIN:
  - out_valid=1, out_data=word out_cnt, out_last=(out_cnt==3).
  - out_cnt advances on out_valid & out_ready.
  - After the handshake on word 3, next state is LOAD; out_valid=0 and in_ready may be 1 in that same next cycle.
  - core_en stays 0 throughout DRAIN (at least 4 cycles), which guarantees the core sees an En low period between blocks.
  - out_data must hold stable while out_valid=1 & out_ready=0.
- core_key and core_data_in are continuous copies of key_reg and blk_reg. blk_reg is not modified in RUN or DRAIN.
- Timing: minimum block turnaround is 4 input + 1 + core latency + 4 output cycles. There is no input/output overlap.

Test Plan:
- Bench core stub: asserts done D cycles after En rises, data_out = data_in ^ key[255:128].
- Reset, load key f4df1409a310982dd708613b072c351f81777d85f0ae732bbe71ca1510eb3d60 (8 words), then data 2a179373117e3de9969f402ee2bec16b, stub D=14 -> core_en rises 1 cycle after 4th data word; out words in order 2a179373^f4df1409, 117e3de9^a310982d, 969f402e^d708613b, e2bec16b^072c351f; out_last on the 4th word; key_valid=1 throughout.
- Data words before any key, then key load -> in_ready=0 for data until key_valid=1; no core_en pulse before then.
- out_ready toggled 1/0 every cycle during DRAIN -> each word held stable while stalled; exactly 4 handshakes; core_en=0 in every DRAIN cycle.
- Stub never asserts done, TIMEOUT_CYCLES=64 -> error=1 and core_en=0 exactly 64 RUN cycles after entry, state LOAD; next block completes normally; error clears on the next key load.
- Rst=1 for one cycle mid-RUN and mid-DRAIN -> all outputs 0 the next cycle, key_valid=0, data words stall until a new key is loaded.
- Second block with the same key, no key reload -> correct result; key word offered after 2 data words -> stalled until the block finishes.
